// File: rtl/sc_regshiftrow.sv
// Paced row shift register with registered active-low TARGET comparator.
// Optional rotate-left on code 10 is enabled by defining SC_REGSHIFTROW_ROTATE_EN.
module sc_regshiftrow #(
  parameter int                   DATAWIDTH = 8,
  parameter int                   TICK_DIV  = 4,
  parameter logic [DATAWIDTH-1:0] TARGET    = 8'h80
) (
  input  logic                 SC_REGSHIFTROW_CLOCK_50,
  input  logic                 SC_REGSHIFTROW_RESET_InHigh,
  input  logic                 SC_REGSHIFTROW_clear_InLow,
  input  logic                 SC_REGSHIFTROW_load_InLow,
  input  logic [1:0]           SC_REGSHIFTROW_shiftselection_In,
  input  logic [DATAWIDTH-1:0] SC_REGSHIFTROW_data_InBUS,
  output logic [DATAWIDTH-1:0] SC_REGSHIFTROW_data_OutBUS,
  output logic                 SC_REGSHIFTROW_LastRegisterComparator_OutLow,
  output logic                 SC_REGSHIFTROW_shiftedOut_Out
);

  localparam int            PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [DATAWIDTH-1:0] row_q, row_d;
  logic [PW-1:0]        pre_q, pre_d;
  logic                 so_q, so_d;
  logic                 cmp_q, cmp_d;
  logic                 run;

  // Code 11 always holds; code 10 holds too unless rotate is built in.
  always_comb begin
    run = (SC_REGSHIFTROW_shiftselection_In != 2'b11);
`ifndef SC_REGSHIFTROW_ROTATE_EN
    if (SC_REGSHIFTROW_shiftselection_In == 2'b10) run = 1'b0;
`endif
  end

  always_comb begin
    row_d = row_q;
    pre_d = pre_q;
    so_d  = so_q;
    if (!SC_REGSHIFTROW_clear_InLow) begin
      row_d = '0;
      pre_d = '0;
      so_d  = 1'b0;
    end else if (!SC_REGSHIFTROW_load_InLow) begin
      row_d = SC_REGSHIFTROW_data_InBUS;
      pre_d = '0;
    end else if (run) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        case (SC_REGSHIFTROW_shiftselection_In)
          2'b00: begin
            row_d = {row_q[DATAWIDTH-2:0], 1'b0};
            so_d  = row_q[DATAWIDTH-1];
          end
          2'b01: begin
            row_d = {1'b0, row_q[DATAWIDTH-1:1]};
            so_d  = row_q[0];
          end
`ifdef SC_REGSHIFTROW_ROTATE_EN
          2'b10: begin
            row_d = {row_q[DATAWIDTH-2:0], row_q[DATAWIDTH-1]};
            so_d  = row_q[DATAWIDTH-1];
          end
`endif
          default: ;
        endcase
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    cmp_d = (row_d != TARGET);
  end

  // Row and comparator update together so the flag always matches the row.
  always_ff @(posedge SC_REGSHIFTROW_CLOCK_50) begin
    if (SC_REGSHIFTROW_RESET_InHigh) begin
      row_q <= '0;
      pre_q <= '0;
      so_q  <= 1'b0;
      cmp_q <= 1'b1;
    end else begin
      row_q <= row_d;
      pre_q <= pre_d;
      so_q  <= so_d;
      cmp_q <= cmp_d;
    end
  end

  assign SC_REGSHIFTROW_data_OutBUS                   = row_q;
  assign SC_REGSHIFTROW_LastRegisterComparator_OutLow = cmp_q;
  assign SC_REGSHIFTROW_shiftedOut_Out                = so_q;

endmodule

// File: tb/tb_sc_regshiftrow.sv
// Bench for sc_regshiftrow: directed vector table, reset sequence and randomized model run.
module tb_sc_regshiftrow;

`ifdef SC_REGSHIFTROW_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clr_n, ld_n;
  logic [1:0] sel;
  logic [7:0] din, dout;
  logic       cmp_n, so;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_row, m_pre;
  bit m_so, m_cmp;

  typedef struct {
    bit       clr_n;
    bit       ld_n;
    bit [1:0] sel;
    bit [7:0] data;
    int       ncyc;
    bit [7:0] exp_row;
    bit       exp_so;
    bit       exp_cmp;
  } vec_t;

  vec_t vecs[$];

  sc_regshiftrow #(.DATAWIDTH(8), .TICK_DIV(4), .TARGET(8'h80)) dut (
    .SC_REGSHIFTROW_CLOCK_50                      (clk),
    .SC_REGSHIFTROW_RESET_InHigh                  (rst),
    .SC_REGSHIFTROW_clear_InLow                   (clr_n),
    .SC_REGSHIFTROW_load_InLow                    (ld_n),
    .SC_REGSHIFTROW_shiftselection_In             (sel),
    .SC_REGSHIFTROW_data_InBUS                    (din),
    .SC_REGSHIFTROW_data_OutBUS                   (dout),
    .SC_REGSHIFTROW_LastRegisterComparator_OutLow (cmp_n),
    .SC_REGSHIFTROW_shiftedOut_Out                (so)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit c, input bit l, input bit [1:0] s, input int d);
    if (r) begin
      m_row = 0; m_pre = 0; m_so = 0; m_cmp = 1;
      return;
    end
    if (!c) begin
      m_row = 0; m_pre = 0; m_so = 0;
    end else if (!l) begin
      m_row = d; m_pre = 0;
    end else if (s != 2'b11 && (ROT || s != 2'b10)) begin
      if (m_pre == 3) begin
        m_pre = 0;
        if (s == 2'b00) begin
          m_so = (m_row >= 128); m_row = (m_row * 2) % 256;
        end else if (s == 2'b01) begin
          m_so = m_row % 2; m_row = m_row / 2;
        end else begin
          m_so = (m_row >= 128); m_row = (m_row * 2) % 256 + m_row / 128;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    m_cmp = (m_row != 128);
  endtask

  task automatic step(input bit r, input bit c, input bit l, input bit [1:0] s, input bit [7:0] d);
    rst = r; clr_n = c; ld_n = l; sel = s; din = d;
    @(posedge clk);
    model(r, c, l, s, int'(d));
    #1;
  endtask

  task automatic check_all(input string tag, input bit [7:0] er, input bit es, input bit ec);
    check({tag, ".row"}, int'(dout), int'(er));
    check({tag, ".so"},  int'(so),   int'(es));
    check({tag, ".cmp"}, int'(cmp_n), int'(ec));
  endtask

  initial begin
    rst = 1'b1; clr_n = 1'b1; ld_n = 1'b1; sel = 2'b11; din = 8'h00;
    m_row = 0; m_pre = 0; m_so = 0; m_cmp = 1;

    // reset held 3 cycles with arbitrary inputs
    step(1, 0, 0, 2'b00, 8'h80);
    step(1, 1, 0, 2'b01, 8'h80);
    step(1, 1, 1, 2'b00, 8'h5A);
    check_all("reset", 8'h00, 1'b0, 1'b1);
    step(0, 1, 1, 2'b11, 8'h00);
    check_all("post_reset", 8'h00, 1'b0, 1'b1);

    // {clr_n, ld_n, sel, data, cycles, row, so, cmp}
    vecs.push_back('{1, 0, 2'b11, 8'h01, 1,  8'h01, 0, 1});
    vecs.push_back('{1, 1, 2'b00, 8'h00, 3,  8'h01, 0, 1});
    vecs.push_back('{1, 1, 2'b00, 8'h00, 1,  8'h02, 0, 1});
    vecs.push_back('{1, 1, 2'b00, 8'h00, 23, 8'h40, 0, 1});
    vecs.push_back('{1, 1, 2'b00, 8'h00, 1,  8'h80, 0, 0});
    vecs.push_back('{1, 1, 2'b00, 8'h00, 4,  8'h00, 1, 1});
    vecs.push_back('{1, 1, 2'b00, 8'h00, 4,  8'h00, 0, 1});
    vecs.push_back('{1, 0, 2'b11, 8'h80, 1,  8'h80, 0, 0});
    vecs.push_back('{1, 1, 2'b01, 8'h00, 2,  8'h80, 0, 0});
    vecs.push_back('{1, 1, 2'b11, 8'h00, 5,  8'h80, 0, 0});
    vecs.push_back('{1, 1, 2'b01, 8'h00, 1,  8'h80, 0, 0});
    vecs.push_back('{1, 1, 2'b01, 8'h00, 1,  8'h40, 0, 1});
    vecs.push_back('{0, 0, 2'b01, 8'h80, 1,  8'h00, 0, 1});
    vecs.push_back('{1, 0, 2'b00, 8'h0F, 1,  8'h0F, 0, 1});
    vecs.push_back('{1, 1, 2'b00, 8'h00, 3,  8'h0F, 0, 1});
    vecs.push_back('{1, 0, 2'b00, 8'hAA, 1,  8'hAA, 0, 1});
    vecs.push_back('{1, 1, 2'b00, 8'h00, 3,  8'hAA, 0, 1});
    vecs.push_back('{1, 1, 2'b00, 8'h00, 1,  8'h54, 1, 1});
    vecs.push_back('{1, 0, 2'b11, 8'h81, 1,  8'h81, 1, 1});
    vecs.push_back('{1, 1, 2'b10, 8'h00, 4,  ROT ? 8'h03 : 8'h81, 1, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      for (int n = 0; n < vecs[i].ncyc; n++)
        step(0, vecs[i].clr_n, vecs[i].ld_n, vecs[i].sel, vecs[i].data);
      check_all($sformatf("vec%0d", i), vecs[i].exp_row, vecs[i].exp_so, vecs[i].exp_cmp);
    end

    // reset mid-count: load 01, shift-left to prescaler 2, then reset
    step(0, 1, 0, 2'b11, 8'h01);
    step(0, 1, 1, 2'b00, 8'h00);
    step(0, 1, 1, 2'b00, 8'h00);
    step(1, 1, 1, 2'b00, 8'h00);
    check_all("midrst", 8'h00, 1'b0, 1'b1);
    step(0, 1, 0, 2'b00, 8'h40);
    for (int n = 0; n < 3; n++) step(0, 1, 1, 2'b00, 8'h00);
    check_all("midrst_pre", 8'h40, 1'b0, 1'b1);
    step(0, 1, 1, 2'b00, 8'h00);
    check_all("midrst_step", 8'h80, 1'b0, 1'b0);

    // randomized run against the reference model
    for (int n = 0; n < 600; n++) begin
      bit       r, c, l;
      bit [1:0] s;
      bit [7:0] d;
      r = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 15) != 0);
      l = ($urandom_range(0, 9) != 0);
      s = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      step(r, c, l, s, d);
      check_all("rand", 8'(m_row), m_so, m_cmp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
